// File: rtl/cla_pkg.sv
// Shared types and helpers for the byte-serial CLA adder.
package cla_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow: operands agree in sign, result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return ~(a_msb ^ b_msb) & (a_msb ^ s_msb);
  endfunction

endpackage

// File: rtl/cla_adder_8bit.sv
// 8-bit combinational carry-lookahead adder slice.
module cla_adder_8bit
  import cla_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carry_in_0,
  output logic [BYTE_W-1:0] sum,
  output logic              carry_out
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;
  logic              pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat sum-of-products of generates and propagate chains.
  always_comb begin
    c    = '0;
    pp   = 1'b0;
    c[0] = carry_in_0;
    for (int i = 0; i < BYTE_W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & carry_in_0);
    end
  end

  assign sum       = p ^ c[BYTE_W-1:0];
  assign carry_out = c[BYTE_W];

endmodule

// File: rtl/cla_byte_serial_adder.sv
// W-bit add/subtract reusing one 8-bit CLA slice, one byte per clock LSB first.
module cla_byte_serial_adder
  import cla_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*NUM_BYTES-1:0]    a,
  input  logic [8*NUM_BYTES-1:0]    b,
  input  logic                      carry_in,
  input  logic                      op_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*NUM_BYTES-1:0]    sum,
  output logic                      carry_out,
  output logic                      overflow
);

  localparam int IDX_W = $clog2(NUM_BYTES);

  state_e state_q, state_d;

  logic [NUM_BYTES-1:0][BYTE_W-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic [IDX_W-1:0]                 idx_q;
  logic                             cy_q, cout_q, ovf_q;
  logic [BYTE_W-1:0]                slice_sum;
  logic                             slice_co;
  logic                             last;
  logic                             accept;

  cla_adder_8bit u_slice (
    .a          (a_q[idx_q]),
    .b          (b_q[idx_q]),
    .carry_in_0 (cy_q),
    .sum        (slice_sum),
    .carry_out  (slice_co)
  );

  assign last   = (idx_q == IDX_W'(NUM_BYTES - 1));
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = slice_sum;
  end

  // Partial bytes build up in acc_q so the visible result only changes when complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= op_sub ? ~b : b;
      cy_q  <= op_sub | carry_in;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
      cy_q  <= slice_co;
      if (last) begin
        sum_q  <= acc_d;
        cout_q <= slice_co;
        ovf_q  <= signed_ovf(a_q[NUM_BYTES-1][BYTE_W-1], b_q[NUM_BYTES-1][BYTE_W-1],
                             slice_sum[BYTE_W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_byte_serial_adder.sv
// Scoreboard bench for cla_byte_serial_adder with NUM_BYTES=4.
module tb_cla_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cla_byte_serial_adder #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sub);
    exp_t   e;
    longint sr;
    logic [W:0] t;
    if (sub) begin
      e.s = x - y;
      e.c = (x >= y);
      sr  = longint'($signed(x)) - longint'($signed(y));
    end else begin
      t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.s = t[W-1:0];
      e.c = t[W];
      sr  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    end
    e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sub);
    bit ok = 0;
    @(negedge clk);
    a = x; b = y; carry_in = ci; op_sub = sub; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    sb_q.push_back(model(x, y, ci, sub));
    check_val("accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; carry_in = 1'($urandom); op_sub = 1'($urandom);
      if (out_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pop_check(output exp_t e);
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
      e.s = 'x; e.c = 1'bx; e.v = 1'bx;
    end else begin
      e = sb_q.pop_front();
      check_val("sum", 64'(sum), 64'(e.s));
      check_val("carry_out", 64'(carry_out), 64'(e.c));
      check_val("overflow", 64'(overflow), 64'(e.v));
    end
  endtask

  task automatic recv(input int stall);
    int   n;
    exp_t e;
    wait_valid(n);
    check_val("latency", 64'(n), 64'(NB));
    pop_check(e);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_val("stall_valid", 64'(out_valid), 64'd1);
      check_val("stall_sum", 64'(sum), 64'(e.s));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_hs_valid", 64'(out_valid), 64'd0);
    check_val("post_hs_hold", 64'(sum), 64'(e.s));
  endtask

  initial begin
    int   n;
    exp_t e;
    #3;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_sum", 64'(sum), 64'd0);
    check_val("rst_cout", 64'(carry_out), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk); rst = 1'b0;

    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0); recv(0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0); recv(1);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0); recv(0);
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1); recv(0);
    send(32'h80000000, 32'h00000001, 1'b1, 1'b1); recv(0);

    // Backpressure with a pending request held upstream.
    send(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    wait_valid(n);
    check_val("bp_latency", 64'(n), 64'(NB));
    pop_check(e);
    a = 32'h1; b = 32'h1; carry_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      check_val("bp_out_valid", 64'(out_valid), 64'd1);
      check_val("bp_sum", 64'(sum), 64'(e.s));
      check_val("bp_cout", 64'(carry_out), 64'(e.c));
    end
    out_ready = 1'b1;
    sb_q.push_back(model(32'h1, 32'h1, 1'b0, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_hs_valid", 64'(out_valid), 64'd0);
    check_val("bp_idle_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("bp_accepted", 64'(in_ready), 64'd0);
    recv(0);

    // Abort after two RUN edges.
    send(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", 64'(out_valid), 64'd0);
    check_val("abort_sum", 64'(sum), 64'd0);
    check_val("abort_cout", 64'(carry_out), 64'd0);
    check_val("abort_ovf", 64'(overflow), 64'd0);
    check_val("abort_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check_val("abort_no_result", 64'(out_valid), 64'd0);
    end
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0); recv(0);

    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
      recv(int'($urandom_range(0, 3)));
    end

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
